// File: rtl/vending_machine_param.sv
// Single-product vending controller: accumulates coin credit up to PRICE, dispenses,
// then pays change out one coin at a time over a valid/ready handshake.
module vending_machine_param #(
    parameter int PRICE     = 15,
    parameter int CREDIT_W  = 7,
    parameter int STOCK_MAX = 8,
    parameter int STOCK_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                restock,
    input  logic                change_ready,
    output logic                dispense,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_V   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_V  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME_V    = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER_V = CREDIT_W'(25);
    localparam logic [STOCK_W-1:0]  STOCK_V   = STOCK_W'(STOCK_MAX);

    // Change handshake: a coin is transferred on each edge where
    // change_valid && change_ready; change_coin holds while ready is low.

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_d;
    logic [STOCK_W-1:0]    stock_d;
    logic                  dispense_d, change_valid_d, coin_reject_d;
    logic [1:0]            change_coin_d;

    logic                  coin_any, coin_one, coin_ok;
    logic [CREDIT_W-1:0]   coin_in, sum;

    function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amount);
        if (amount >= QUARTER_V)     return 2'b11;
        else if (amount >= DIME_V)   return 2'b10;
        else if (amount >= NICKEL_V) return 2'b01;
        else                         return 2'b00;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   return NICKEL_V;
            2'b10:   return DIME_V;
            2'b11:   return QUARTER_V;
            default: return '0;
        endcase
    endfunction

    assign coin_any  = nickel | dime | quarter;
    assign coin_one  = $onehot({quarter, dime, nickel});
    assign coin_ok   = coin_one && (stock != '0);
    assign coin_in   = !coin_ok ? '0 : quarter ? QUARTER_V : dime ? DIME_V : NICKEL_V;
    assign sum       = credit + coin_in;
    assign fsm_state = state_q;

    always_comb begin
        state_d        = state_q;
        credit_d       = credit;
        stock_d        = stock;
        dispense_d     = 1'b0;
        change_valid_d = 1'b0;
        change_coin_d  = 2'b00;
        coin_reject_d  = 1'b0;
        case (state_q)
            IDLE: begin
                coin_reject_d = coin_any && !coin_ok;
                credit_d      = sum;
                // A coin that reaches the price vends even when cancel is also high.
                if (sum >= PRICE_V) begin
                    state_d    = VEND;
                    dispense_d = 1'b1;
                end else if (cancel && sum != '0) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_coin_d  = pick_coin(sum);
                end
            end
            VEND: begin
                coin_reject_d = coin_any;
                credit_d      = credit - PRICE_V;
                stock_d       = stock - STOCK_W'(1);
                if (credit_d != '0) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_coin_d  = pick_coin(credit_d);
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d  = coin_any;
                change_valid_d = 1'b1;
                change_coin_d  = change_coin;
                if (change_ready) begin
                    credit_d = credit - coin_value(change_coin);
                    if (credit_d == '0) begin
                        state_d        = IDLE;
                        change_valid_d = 1'b0;
                        change_coin_d  = 2'b00;
                    end else begin
                        change_coin_d = pick_coin(credit_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (restock) stock_d = STOCK_V;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            credit       <= '0;
            stock        <= STOCK_V;
            sold_out     <= 1'b0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= 2'b00;
            coin_reject  <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit       <= credit_d;
            stock        <= stock_d;
            sold_out     <= (stock == '0);
            dispense     <= dispense_d;
            change_valid <= change_valid_d;
            change_coin  <= change_coin_d;
            coin_reject  <= coin_reject_d;
        end
    end

endmodule
